// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
// Owner encodings tag which requester's read is returning this cycle.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DRD  = 2'd2
    } owner_e;

    localparam int MAX_STREAK_DEF = 4;
    localparam int STREAK_W       = 4;

endpackage

// File: rtl/mem_arb_fairness.sv
// Counts consecutive data grants while fetch waits; forces a fetch grant at the limit.
// State updates on the clock edge; force_if is a pure function of the stored count.
module mem_arb_fairness
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic force_if
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    // The count only means something while fetch is actually waiting.
    always_comb begin
        streak_d = streak_q;
        if (if_gnt || !if_req) begin
            streak_d = '0;
        end else if (d_gnt && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_if = (streak_q == STREAK_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 1-cycle-latency single-port RAM between fetch and load/store; data side wins
// unless the fairness streak forces fetch. Grant is combinational, read data returns next cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int MAX_STREAK = MAX_STREAK_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    owner_e owner_q;
    owner_e owner_d;
    logic   flush_pend_q;
    logic   flush_pend_d;
    logic   force_if;
    logic   if_win;
    logic   d_win;

    mem_arb_fairness #(
        .MAX_STREAK (MAX_STREAK)
    ) u_fairness (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_gnt   (if_win),
        .d_gnt    (d_win),
        .force_if (force_if)
    );

    // Grants are masked while reset is held so every output reads zero during reset.
    always_comb begin
        if_win = reset && if_req && (!d_req || force_if);
        d_win  = reset && d_req && !if_win;
    end

    assign if_gnt = if_win;
    assign d_gnt  = d_win;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (if_win) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_addr;
        end else if (d_win) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_NONE;
            flush_pend_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Stores complete at grant, so only reads leave an owner behind.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_win) begin
            owner_d = OWN_IF;
        end else if (d_win && !d_we) begin
            owner_d = OWN_DRD;
        end
        flush_pend_d = if_win && if_flush;
    end

    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = 32'h0;
        d_rvalid  = 1'b0;
        d_rdata   = 32'h0;
        case (owner_q)
            OWN_IF: begin
                if_rvalid = !flush_pend_q && !if_flush;
                if_rdata  = mem_rdata;
            end
            OWN_DRD: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rdata;
            end
            default: begin
                if_rvalid = 1'b0;
                d_rvalid  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency) between the instruction-fetch requester (IF) and the load/store requester (D).
- Sits between the PC/fetch logic, the load/store path, and the unified memory; replaces separate inst/data memories driving a common read bus.
- Enforces one outstanding access and returns read data to the owner.
- Data side has priority; a streak counter guarantees fetch progress; a flush input squashes a returning fetch after a taken jump.

Parameters:
- AW, 32, address width of if_addr, d_addr, mem_addr.
- MAX_STREAK, 4, max consecutive D grants while if_req is pending before IF is forced (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  AW  fetch byte address (word aligned).
- if_flush  in  1  discard any fetch read currently in flight (jump taken).
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_addr  in  AW  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  d_rdata valid (loads only).
- d_rdata  out  32  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_be  out  4  memory byte enables.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid the cycle after a read strobe.

Behaviour:
- Grant decision and mem_* outputs are combinational from requests and current state. Stored state: owner register {NONE, IF, DRD}, flush_pend bit, streak counter (4 bits).
- Grant is possible every cycle; throughput is one access per cycle. A new grant may issue in the same cycle the previous read returns.
- Arbitration when both requests are high:
  - D wins unless streak == MAX_STREAK, in which case IF wins.
  - A single request always wins.
- Memory drive on grant:
  - mem_en = 1; address and data from the winner.
  - For IF: mem_we = 0 and mem_be = 4'hF.
  - For D: mem_we = d_we and mem_be = d_be.
  - With no grant: mem_en = 0, mem_we = 0, mem_be = 0; mem_addr and mem_wdata hold 0.
- Owner register next state: IF on IF grant; DRD on D load grant; NONE on store grant or no grant.
- Read return (cycle after the read grant):
  - owner == IF: if_rvalid = ~flush_pend & ~if_flush; if_rdata = mem_rdata.
  - owner == DRD: d_rvalid = 1; d_rdata = mem_rdata.
  - Otherwise both rvalids = 0 and both rdata = 0.
- Stores: complete at grant; no d_rvalid.
- Flush:
  - flush_pend is set when if_flush is high in the grant cycle of an IF read, and cleared the next cycle.
  - if_flush in the return cycle also suppresses if_rvalid.
  - if_flush does not block a new IF grant in the same cycle.
- Streak counter:
  - Increments (saturating at MAX_STREAK) on a D grant while if_req = 1.
  - Clears on IF grant or when if_req = 0.
- Reset (async, asserted low):
  - owner = NONE, flush_pend = 0, streak = 0.
  - All outputs read 0.
  - A read in flight at reset is dropped; no rvalid after deassertion.
- Requests dropped before grant are legal and leave no state.
- Misaligned addresses are passed through unchanged; alignment checks are out of scope.

Decomposition:
- Shared package/define file: owner encodings (OWN_NONE=2'd0, OWN_IF=2'd1, OWN_DRD=2'd2) and the MAX_STREAK default, alongside the existing WB_* defines.
- Natural sub-module: mem_arb_fairness, holding the streak counter and the force-IF output.

Test Plan:
- Reset low with both requests high -> all outputs 0; after release, first cycle grants D (d_gnt=1, mem_addr=d_addr).
- IF-only read at addr 0x40, mem_rdata=0x00000013 next cycle -> if_gnt at cycle t, if_rvalid=1 with if_rdata=0x13 at t+1, d_rvalid=0.
- Back-to-back D load then IF fetch -> d_rvalid at t+1 and if_gnt at t+1 in the same cycle; if_rvalid at t+2.
- d_req and if_req held high continuously, MAX_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Store d_be=4'b0011 to 0x100 -> mem_we=1, mem_be=0011 in the grant cycle; no d_rvalid.
- IF read granted with if_flush=1 in the same cycle -> if_rvalid stays 0 the next cycle; a subsequent fetch returns normally.
